pdm_tx: RTL and testbench

- First-order sigma-delta PDM modulator: takes unsigned PCM samples and emits a 1-bit PDM stream plus bit clock, e.g. to a speaker/filter pin or a PDM loopback into the mic receive path.
- Density is exactly equivalent to the mic receiver: each sample is played for 2^WIDTH bit periods, and the stream contains exactly `sample` ones in that window.
- Sits between the audio sample source (valid/ready) and the board pin.

---
 rtl/pdm_tx.sv | 130 +++++++++++++
 tb/tb_pdm_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_tx.sv
// rtl/pdm_tx.sv - first-order sigma-delta PDM transmitter with one-deep sample holding register
//
// Purpose:
//   Plays unsigned PCM samples as a 1-bit PDM stream. Each sample is held for
//   2^WIDTH bit periods, and that window contains exactly `sample` ones. New
//   samples arrive through a valid/ready handshake into a one-entry holding
//   register and are promoted to playback only at the end of a period.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       run the modulator; when low, the bit outputs idle at 0
//   s_data       unsigned PCM sample (midscale = 2^(WIDTH-1))
//   s_valid      sample offered
//   s_ready      holding register can accept (combinational)
//   pdm_clk      registered PDM bit clock
//   pdm_out      registered PDM data, changes on the falling edge of pdm_clk
//   sample_tick  one-cycle pulse when a new sample is loaded for playback
//   underrun     one-cycle pulse when a load finds the holding register empty

module pdm_tx #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             pdm_clk,
  output logic             pdm_out,
  output logic             sample_tick,
  output logic             underrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // pdm_clk is low while the upcoming divider count is below this value.
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] BIT_LAST = {WIDTH{1'b1}};

  // Divider and bit position within the current sample period
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [WIDTH-1:0] bit_cnt;
  logic             bit_tick;
  logic             load;

  // Modulator state
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cur_sample;
  logic [WIDTH:0]   sum;

  // Holding register
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             transfer;

  assign s_ready = !hold_full && !reset;

  always_comb begin
    div_next = '0;
    if (enable) begin
      div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
    bit_tick = enable && (div_cnt == DIV_LAST);
    // The last bit of a period both emits its bit (with the old sample) and
    // swaps in the next sample for the following period.
    load     = bit_tick && (bit_cnt == BIT_LAST);
    // The carry out of the accumulator is the PDM bit. Since acc wraps over
    // exactly 2^WIDTH additions of a constant sample, it returns to its
    // starting value, and the carry count equals the sample value.
    sum      = {1'b0, acc} + {1'b0, cur_sample};
    transfer = s_valid && s_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      cur_sample  <= MIDSCALE;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      pdm_clk     <= 1'b0;
      pdm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      // Registered from the next divider value so that pdm_clk falls on the
      // same edge that pdm_out updates; the receiver samples on the rise.
      pdm_clk     <= enable && (div_next >= DIV_HALF);
      sample_tick <= load;
      underrun    <= load && !hold_full;

      if (!enable) begin
        // Stopping abandons the current period; restart always begins with a
        // clean accumulator and a midscale period.
        bit_cnt    <= '0;
        acc        <= '0;
        pdm_out    <= 1'b0;
        cur_sample <= MIDSCALE;
      end else if (bit_tick) begin
        acc     <= sum[WIDTH-1:0];
        pdm_out <= sum[WIDTH];
        bit_cnt <= bit_cnt + WIDTH'(1);
      end

      if (load) begin
        cur_sample <= hold_full ? hold_data : MIDSCALE;
        if (hold_full) begin
          hold_full <= 1'b0;
        end
      end

      // s_ready excludes a full register, so a transfer can never collide
      // with the load that empties it. A transfer on the load cycle of an
      // empty register lands in hold_data only; there is no bypass.
      if (transfer) begin
        hold_data <= s_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_tx.sv
// tb/tb_pdm_tx.sv - randomized self-checking bench for pdm_tx against a period-level arithmetic model
//
// Purpose:
//   Drives sample pushes, reset and enable interruptions into pdm_tx and
//   compares every cycle's outputs with a model that derives each bit from the
//   closed form floor((k+1)*S/OSR) - floor(k*S/OSR). A receiver-side counter
//   also checks the ones count of each complete period.
//
// Ports: none (top-level bench)

module tb_pdm_tx;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 15;
  localparam int OSR     = 1 << WIDTH;
  localparam int PERIOD  = OSR * CLK_DIV;
  localparam int MID     = OSR / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             pdm_clk;
  logic             pdm_out;
  logic             sample_tick;
  logic             underrun;

  int n_cmp = 0;
  int n_bad = 0;

  pdm_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .pdm_clk     (pdm_clk),
    .pdm_out     (pdm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: clocked events computed from elapsed enabled cycles.
  int ph       = 0;   // enabled clk edges since last restart
  int m_cur    = MID; // sample currently playing
  int m_hold   = 0;
  bit m_full   = 1'b0;
  bit e_clk    = 1'b0;
  bit e_out    = 1'b0;
  bit e_tick   = 1'b0;
  bit e_under  = 1'b0;
  bit armed    = 1'b0;

  always @(posedge clk) begin
    bit xfer;
    int k;
    if (reset) begin
      ph = 0; m_cur = MID; m_full = 1'b0;
      e_clk = 1'b0; e_out = 1'b0; e_tick = 1'b0; e_under = 1'b0;
      armed = 1'b1;
    end else begin
      xfer = s_valid && !m_full;
      e_tick = 1'b0;
      e_under = 1'b0;
      if (!enable) begin
        ph = 0; m_cur = MID; e_clk = 1'b0; e_out = 1'b0;
      end else begin
        if (ph % CLK_DIV == CLK_DIV - 1) begin
          k = (ph / CLK_DIV) % OSR;
          e_out = ((((k + 1) * m_cur) / OSR) - ((k * m_cur) / OSR)) != 0;
          if (k == OSR - 1) begin
            e_tick = 1'b1;
            if (m_full) begin
              m_cur = m_hold;
              m_full = 1'b0;
            end else begin
              m_cur = MID;
              e_under = 1'b1;
            end
          end
        end
        ph++;
        e_clk = (ph % CLK_DIV) >= (CLK_DIV / 2);
      end
      if (xfer) begin
        m_hold = int'(s_data);
        m_full = 1'b1;
      end
    end
  end

  // Cycle-level comparison plus a receiver that samples pdm_out on pdm_clk rise.
  bit prev_clk  = 1'b0;
  bit rx_first  = 1'b1;
  int rx_bits   = 0;
  int rx_ones   = 0;
  int rx_sample = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("outs", {27'd0, s_ready, pdm_clk, pdm_out, sample_tick, underrun},
            {27'd0, !m_full && !reset, e_clk, e_out, e_tick, e_under});
      if (reset || !enable) begin
        rx_first = 1'b1;
        rx_bits  = 0;
        rx_ones  = 0;
      end else if (pdm_clk && !prev_clk) begin
        // The first high phase after a restart precedes the first computed bit.
        if (rx_first) begin
          rx_first = 1'b0;
        end else begin
          if (rx_bits == 0) rx_sample = m_cur;
          rx_ones += int'(pdm_out);
          rx_bits++;
          if (rx_bits == OSR) begin
            check("ones_per_period", rx_ones, rx_sample);
            rx_bits = 0;
            rx_ones = 0;
          end
        end
      end
      prev_clk = pdm_clk;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bit done = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 2 * PERIOD && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_data  = WIDTH'($urandom);
    check("push_accept", 32'(done), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    wait_cycles(3);
    reset = 1'b0;
    enable = 1'b1;

    // Midscale start-up period, then the pushed samples in order.
    push(8'h00);
    push(8'h80);
    push(8'hFF);
    push(8'h01);
    // Let 0x01 play and the following load underrun.
    wait_cycles(2 * PERIOD + 100);

    // Back-to-back pushes stall on s_ready until each load.
    push(8'h10);
    push(8'h20);
    push(8'h30);
    wait_cycles(2 * PERIOD + 100);

    // Reset mid-period discards the held sample.
    x = WIDTH'($urandom);
    push(x);
    wait_cycles($urandom_range(PERIOD / 2, 50));
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(PERIOD + 100);

    // Enable low mid-period for 100 clk, then midscale period, then held sample.
    y = WIDTH'($urandom);
    push(y);
    wait_cycles($urandom_range(1000, 50));
    enable = 1'b0;
    wait_cycles(100);
    enable = 1'b1;
    wait_cycles(2 * PERIOD + 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
